// File: rtl/gremlin_pkg.sv
// gremlin_pkg: shared definitions for the DeathRace gremlin generator.
//   - gremlin state and direction encodings
//   - sprite dimensions (GREMW, GREMCARH)
//   - LFSR tap mask and next-state helper
//   - field offsets of the 24-bit packed gremlin word shared with collision:
//       [23] reserved (0), [22:12] x, [11:1] y, [0] active
package gremlin_pkg;

  localparam int unsigned GREMW    = 16;
  localparam int unsigned GREMCARH = 32;

  typedef enum logic [1:0] {
    ST_DEAD = 2'd0,
    ST_WALK = 2'd1,
    ST_HALT = 2'd2
  } grem_state_e;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } grem_dir_e;

  // Fibonacci taps 16,14,13,11 -> register bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned POS_W    = 11;
  localparam int unsigned W_ACTIVE = 0;
  localparam int unsigned W_Y_LSB  = 1;
  localparam int unsigned W_Y_MSB  = 11;
  localparam int unsigned W_X_LSB  = 12;
  localparam int unsigned W_X_MSB  = 22;
  localparam int unsigned W_RSVD   = 23;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Axis directions differ only in bit 1, so reversal flips that bit.
  function automatic grem_dir_e dir_reverse(input grem_dir_e d);
    logic [1:0] v;
    v = d;
    return grem_dir_e'({~v[1], v[0]});
  endfunction

  // A 10-bit random coordinate past the axis limit is folded down by 512,
  // which always lands it back inside the field.
  function automatic logic [POS_W-1:0] spawn_fold(input logic [9:0] raw,
                                                  input logic [POS_W-1:0] lim);
    logic [POS_W-1:0] v;
    v = {1'b0, raw};
    return (v >= lim) ? v - 11'd512 : v;
  endfunction

endpackage

// File: rtl/gremlin_fsm.sv
// gremlin_fsm: one gremlin (spawn / walk / bounce / die / respawn / halt).
// Ports:
//   clk_i      pixel clock
//   rst_ni     asynchronous active-low reset
//   tick_i     frame tick (one clk wide)
//   kill_i     collision hit (honoured only while walking)
//   timeout_i  round over; freezes the gremlin until reset
//   lfsr_i     shared LFSR state used for spawn position and direction
//   swap_i     0: x=lfsr[9:0], y=lfsr[15:6], dir=lfsr[1:0]
//              1: x=lfsr[15:6], y=lfsr[9:0], dir=lfsr[3:2]
//   grem_o     packed word {0, x, y, active}
module gremlin_fsm
  import gremlin_pkg::*;
#(
  parameter int unsigned X_MAX          = 784,
  parameter int unsigned Y_MAX          = 568,
  parameter int unsigned STEP           = 2,
  parameter int unsigned DIR_FRAMES     = 32,
  parameter int unsigned RESPAWN_FRAMES = 120
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        kill_i,
  input  logic        timeout_i,
  input  logic [15:0] lfsr_i,
  input  logic        swap_i,
  output logic [23:0] grem_o
);

  localparam int unsigned FCW = $clog2(DIR_FRAMES + 1);
  localparam int unsigned RCW = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [POS_W-1:0] XM     = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YM     = POS_W'(Y_MAX);
  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic [FCW-1:0]   F_LAST = FCW'(DIR_FRAMES - 1);
  localparam logic [RCW-1:0]   R_LOAD = RCW'(RESPAWN_FRAMES);

  grem_state_e      state_q, state_d;
  grem_dir_e        dir_q, dir_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic             active_q, active_d;

  logic [9:0]         raw_x, raw_y;
  grem_dir_e          dir_rand;
  logic               horiz, fwd, blocked;
  logic [POS_W-1:0]   pos, lim;
  logic signed [11:0] nxt;

  always_comb begin
    raw_x    = swap_i ? lfsr_i[15:6] : lfsr_i[9:0];
    raw_y    = swap_i ? lfsr_i[9:0]  : lfsr_i[15:6];
    dir_rand = grem_dir_e'(swap_i ? lfsr_i[3:2] : lfsr_i[1:0]);

    horiz   = (dir_q == DIR_RIGHT) || (dir_q == DIR_LEFT);
    fwd     = (dir_q == DIR_RIGHT) || (dir_q == DIR_DOWN);
    pos     = horiz ? x_q : y_q;
    lim     = horiz ? XM : YM;
    nxt     = fwd ? $signed({1'b0, pos}) + STEP_S : $signed({1'b0, pos}) - STEP_S;
    blocked = (nxt < 12'sd0) || (nxt > $signed({1'b0, lim}));
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    fcnt_d  = fcnt_q;
    rcnt_d  = rcnt_q;

    if (timeout_i) begin
      state_d = ST_HALT;
    end else begin
      unique case (state_q)
        ST_DEAD: begin
          if (tick_i) begin
            if (rcnt_q <= RCW'(1)) begin
              state_d = ST_WALK;
              x_d     = spawn_fold(raw_x, XM);
              y_d     = spawn_fold(raw_y, YM);
              fcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q - RCW'(1);
            end
          end
        end
        ST_WALK: begin
          if (kill_i) begin
            state_d = ST_DEAD;
            rcnt_d  = R_LOAD;
          end else if (tick_i) begin
            if (blocked) begin
              dir_d = dir_reverse(dir_q);
            end else if (horiz) begin
              x_d = nxt[POS_W-1:0];
            end else begin
              y_d = nxt[POS_W-1:0];
            end
            // A scheduled random reload takes precedence over a bounce reversal.
            if (fcnt_q == F_LAST) begin
              fcnt_d = '0;
              dir_d  = dir_rand;
            end else begin
              fcnt_d = fcnt_q + FCW'(1);
            end
          end
        end
        ST_HALT: ;
        default: state_d = ST_DEAD;
      endcase
    end

    active_d = (state_d == ST_WALK);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_DEAD;
      dir_q    <= DIR_RIGHT;
      x_q      <= '0;
      y_q      <= '0;
      fcnt_q   <= '0;
      rcnt_q   <= RCW'(1);
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fcnt_q   <= fcnt_d;
      rcnt_q   <= rcnt_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    grem_o                   = '0;
    grem_o[W_X_MSB:W_X_LSB]  = x_q;
    grem_o[W_Y_MSB:W_Y_LSB]  = y_q;
    grem_o[W_ACTIVE]         = active_q;
  end

endmodule

// File: rtl/gremlin_ctrl.sv
// gremlin_ctrl: generates the two playfield gremlins for collision.
// Ports:
//   clk             pixel clock
//   rst             asynchronous active-low reset
//   vsync_in        VGA vsync; rising edge = frame tick
//   TimeOut         round over (level); freezes both gremlins until reset
//   grem0_alive_in  0 = gremlin 0 hit by collision
//   grem1_alive_in  0 = gremlin 1 hit by collision
//   grem0, grem1    packed words {0, x[10:0], y[10:0], active}
module gremlin_ctrl
  import gremlin_pkg::*;
#(
  parameter int unsigned X_MAX          = 784,
  parameter int unsigned Y_MAX          = 568,
  parameter int unsigned STEP           = 2,
  parameter int unsigned DIR_FRAMES     = 32,
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        TimeOut,
  input  logic        grem0_alive_in,
  input  logic        grem1_alive_in,
  output logic [23:0] grem0,
  output logic [23:0] grem1
);

  logic        vsync_q;
  logic [15:0] lfsr_q;
  logic        tick;

  // vsync_q clears on reset, so a vsync already high at release is a tick.
  assign tick = vsync_in & ~vsync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      lfsr_q  <= SEED;
    end else begin
      vsync_q <= vsync_in;
      lfsr_q  <= lfsr_next(lfsr_q);
    end
  end

  gremlin_fsm #(
    .X_MAX         (X_MAX),
    .Y_MAX         (Y_MAX),
    .STEP          (STEP),
    .DIR_FRAMES    (DIR_FRAMES),
    .RESPAWN_FRAMES(RESPAWN_FRAMES)
  ) u_grem0 (
    .clk_i    (clk),
    .rst_ni   (rst),
    .tick_i   (tick),
    .kill_i   (~grem0_alive_in),
    .timeout_i(TimeOut),
    .lfsr_i   (lfsr_q),
    .swap_i   (1'b0),
    .grem_o   (grem0)
  );

  gremlin_fsm #(
    .X_MAX         (X_MAX),
    .Y_MAX         (Y_MAX),
    .STEP          (STEP),
    .DIR_FRAMES    (DIR_FRAMES),
    .RESPAWN_FRAMES(RESPAWN_FRAMES)
  ) u_grem1 (
    .clk_i    (clk),
    .rst_ni   (rst),
    .tick_i   (tick),
    .kill_i   (~grem1_alive_in),
    .timeout_i(TimeOut),
    .lfsr_i   (lfsr_q),
    .swap_i   (1'b1),
    .grem_o   (grem1)
  );

endmodule

// File: tb/tb_gremlin_ctrl.sv
// Self-checking bench for gremlin_ctrl with a behavioural gremlin model.
module tb_gremlin_ctrl;

  localparam int XMAX = 784;
  localparam int YMAX = 568;
  localparam int STEP = 2;
  localparam int DIRF = 32;
  localparam int RESP = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync_in = 1'b0;
  logic        TimeOut = 1'b0;
  logic        a0 = 1'b1;
  logic        a1 = 1'b1;
  logic [23:0] grem0, grem1;

  gremlin_ctrl #(
    .X_MAX(XMAX), .Y_MAX(YMAX), .STEP(STEP), .DIR_FRAMES(DIRF),
    .RESPAWN_FRAMES(RESP), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .TimeOut(TimeOut),
    .grem0_alive_in(a0), .grem1_alive_in(a1), .grem0(grem0), .grem1(grem1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mx[2], my[2], mdir[2], mfc[2], mcnt[2];
  bit malive[2], mhalt[2];
  int unsigned mlfsr;
  bit mvsq, mtick;

  function automatic int unsigned lfsr_adv(input int unsigned l);
    int unsigned fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 16'hFFFF;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      mx[g] = 0; my[g] = 0; mdir[g] = 0; mfc[g] = 0; mcnt[g] = 1;
      malive[g] = 0; mhalt[g] = 0;
    end
    mlfsr = SEED;
    mvsq  = 0;
    mtick = 0;
  endtask

  task automatic spawn(input int g);
    int lo, hi, sx, sy;
    lo = int'(mlfsr & 32'h3FF);
    hi = int'((mlfsr >> 6) & 32'h3FF);
    sx = (g == 1) ? hi : lo;
    sy = (g == 1) ? lo : hi;
    if (sx >= XMAX) sx -= 512;
    if (sy >= YMAX) sy -= 512;
    mx[g] = sx; my[g] = sy; malive[g] = 1; mfc[g] = 0;
  endtask

  task automatic walk(input int g);
    int nx, ny;
    nx = mx[g]; ny = my[g];
    case (mdir[g])
      0: nx += STEP;
      1: ny += STEP;
      2: nx -= STEP;
      default: ny -= STEP;
    endcase
    if (nx < 0 || nx > XMAX || ny < 0 || ny > YMAX) mdir[g] ^= 2;
    else begin mx[g] = nx; my[g] = ny; end
    mfc[g]++;
    if (mfc[g] == DIRF) begin
      mfc[g]  = 0;
      mdir[g] = (g == 1) ? int'((mlfsr >> 2) & 3) : int'(mlfsr & 3);
    end
  endtask

  task automatic model_step(input bit vs, input bit to, input bit al0, input bit al1);
    bit al[2];
    al[0] = al0; al[1] = al1;
    mtick = vs && !mvsq;
    mvsq  = vs;
    for (int g = 0; g < 2; g++) begin
      if (to) begin
        mhalt[g] = 1; malive[g] = 0;
      end else if (!mhalt[g]) begin
        if (malive[g] && !al[g]) begin
          malive[g] = 0; mcnt[g] = RESP;
        end else if (mtick) begin
          if (!malive[g]) begin
            if (mcnt[g] == 1) spawn(g);
            else mcnt[g]--;
          end else begin
            walk(g);
          end
        end
      end
    end
    mlfsr = lfsr_adv(mlfsr);
  endtask

  function automatic logic [23:0] exp_word(input int g);
    return {1'b0, 11'(mx[g]), 11'(my[g]), malive[g]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic motion_checks(input logic [23:0] p, input logic [23:0] c);
    int px, py, cx, cy, d;
    bit near;
    px = int'(p[22:12]); py = int'(p[11:1]);
    cx = int'(c[22:12]); cy = int'(c[11:1]);
    check("x_bound", 24'(cx <= XMAX), 24'd1);
    check("y_bound", 24'(cy <= YMAX), 24'd1);
    d = ((cx > px) ? cx - px : px - cx) + ((cy > py) ? cy - py : py - cy);
    check("step_size", 24'(d == 0 || d == STEP), 24'd1);
    if (d == 0) begin
      near = (px < STEP) || (px > XMAX - STEP) || (py < STEP) || (py > YMAX - STEP);
      check("hold_edge", 24'(near), 24'd1);
    end
  endtask

  task automatic step();
    logic [23:0] p0, p1;
    p0 = grem0; p1 = grem1;
    @(posedge clk);
    if (rst) model_step(vsync_in, TimeOut, a0, a1);
    #1;
    check("g0", grem0, exp_word(0));
    check("g1", grem1, exp_word(1));
    if (rst && mtick) begin
      if (p0[0] && grem0[0]) motion_checks(p0, grem0);
      if (p1[0] && grem1[0]) motion_checks(p1, grem1);
    end
  endtask

  task automatic rand_kill(input int permille);
    a0 = !(permille > 0 && $urandom_range(0, 999) < permille);
    a1 = !(permille > 0 && $urandom_range(0, 999) < permille);
  endtask

  task automatic frame(input int lo, input int hi, input int permille);
    vsync_in = 1'b0;
    repeat (lo) begin rand_kill(permille); step(); end
    vsync_in = 1'b1;
    repeat (hi) begin rand_kill(permille); step(); end
    a0 = 1'b1; a1 = 1'b1;
  endtask

  logic [23:0] w0, w1;

  initial begin
    model_reset();
    repeat (3) step();
    check("rst_g0", grem0, 24'h0);
    check("rst_g1", grem1, 24'h0);
    rst = 1'b1;
    repeat (3) step();
    check("pre_tick_g0", grem0, 24'h0);

    // first tick spawns both
    frame(2, 2, 0);
    check("spawn_act0", 24'(grem0[0]), 24'd1);
    check("spawn_act1", 24'(grem1[0]), 24'd1);
    check("spawn_x0", 24'(int'(grem0[22:12]) <= XMAX), 24'd1);
    check("spawn_y1", 24'(int'(grem1[11:1]) <= YMAX), 24'd1);

    repeat (5) frame(3, 2, 0);

    // single-cycle kill of gremlin 0 away from a tick
    vsync_in = 1'b0;
    step();
    w0 = grem0; w1 = grem1;
    a0 = 1'b0;
    step();
    a0 = 1'b1;
    check("kill_act", 24'(grem0[0]), 24'd0);
    check("kill_pos", 24'(grem0[23:1]), 24'(w0[23:1]));
    check("kill_g1", grem1, w1);
    for (int t = 1; t <= RESP; t++) begin
      frame(2, 2, 0);
      if (t < RESP) begin
        check("dead_act", 24'(grem0[0]), 24'd0);
        check("dead_pos", 24'(grem0[23:1]), 24'(w0[23:1]));
      end else begin
        check("respawn_act", 24'(grem0[0]), 24'd1);
      end
      check("g1_alive", 24'(grem1[0]), 24'd1);
    end

    // kill on the same edge as a tick
    vsync_in = 1'b0;
    step(); step();
    w0 = grem0;
    vsync_in = 1'b1;
    a0 = 1'b0;
    step();
    a0 = 1'b1;
    check("kt_act", 24'(grem0[0]), 24'd0);
    check("kt_pos", 24'(grem0[23:1]), 24'(w0[23:1]));

    // long randomized run
    for (int f = 0; f < 5000; f++)
      frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 3);

    // round timeout
    repeat (10) frame(2, 2, 0);
    vsync_in = 1'b0;
    TimeOut  = 1'b1;
    step();
    check("to_act0", 24'(grem0[0]), 24'd0);
    check("to_act1", 24'(grem1[0]), 24'd0);
    w0 = grem0; w1 = grem1;
    for (int f = 0; f < 200; f++) begin
      frame(2, 2, 3);
      check("halt_g0", grem0, w0);
      check("halt_g1", grem1, w1);
    end

    // asynchronous reset with vsync high mid-frame
    vsync_in = 1'b1;
    step();
    #1 rst = 1'b0;
    #1;
    check("arst_g0", grem0, 24'h0);
    check("arst_g1", grem1, 24'h0);
    model_reset();
    TimeOut = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    check("rel_spawn0", 24'(grem0[0]), 24'd1);
    check("rel_spawn1", 24'(grem1[0]), 24'd1);
    repeat (20) frame(2, 2, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
